// File: rtl/iomem_arbiter.sv
// Two-requester round-robin arbiter onto a single iomem slave bus.
// One transfer in flight at a time; optional slave-response timeout returns ERR_RDATA.
module iomem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,

  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,

  output logic        s_valid,
  input  logic        s_ready,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic [31:0] s_rdata,

  output logic        timeout
);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  localparam bit          TimeoutEn   = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] TimeoutLast = TimeoutEn ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

  state_e      state_q;
  logic        owner_q;
  logic        last_grant_q;
  logic [15:0] cnt_q;

  logic grant;
  logic timeout_hit;

  // On a tie the requester not served last wins; otherwise the sole requester wins.
  assign grant       = (m0_valid && m1_valid) ? ~last_grant_q : m1_valid;
  assign timeout_hit = TimeoutEn && (cnt_q == TimeoutLast);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= 16'd0;
      s_valid      <= 1'b0;
      s_addr       <= 32'd0;
      s_wdata      <= 32'd0;
      s_wstrb      <= 4'd0;
      m0_rdata     <= 32'd0;
      m1_rdata     <= 32'd0;
      m0_ready     <= 1'b0;
      m1_ready     <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      m0_ready <= 1'b0;
      m1_ready <= 1'b0;
      timeout  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (m0_valid || m1_valid) begin
            owner_q      <= grant;
            last_grant_q <= grant;
            s_addr       <= grant ? m1_addr  : m0_addr;
            s_wdata      <= grant ? m1_wdata : m0_wdata;
            s_wstrb      <= grant ? m1_wstrb : m0_wstrb;
            cnt_q        <= 16'd0;
            s_valid      <= 1'b1;
            state_q      <= StBusy;
          end
        end
        StBusy: begin
          if (cnt_q != 16'hFFFF) begin
            cnt_q <= cnt_q + 16'd1;
          end
          // A slave response in the timeout cycle takes priority over the timeout.
          if (s_ready || timeout_hit) begin
            if (owner_q) begin
              m1_rdata <= s_ready ? s_rdata : ERR_RDATA;
              m1_ready <= 1'b1;
            end else begin
              m0_rdata <= s_ready ? s_rdata : ERR_RDATA;
              m0_ready <= 1'b1;
            end
            timeout <= !s_ready;
            s_valid <= 1'b0;
            state_q <= StResp;
          end
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          s_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iomem_arbiter.sv
// Scoreboard bench for iomem_arbiter: directed scenarios plus random two-requester traffic
// checked against a transaction-level arbitration and slave-response model.
module tb_iomem_arbiter;

  localparam int unsigned TO  = 4;
  localparam logic [31:0] ERR = 32'hFFFF_FFFF;

  typedef struct {
    logic [31:0] rd;
    bit          to;
  } exp_t;

  typedef struct {
    int          d;
    logic [31:0] data;
  } dir_t;

  logic        clk;
  logic        resetn;
  logic        mv   [2];
  logic [3:0]  mws  [2];
  logic [31:0] ma   [2];
  logic [31:0] mwd  [2];
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid, s_ready;
  logic [3:0]  s_wstrb;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic        timeout;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   sv_cnt = 0;
  int   issued = 0;
  int   done = 0;
  int   last_served = 1;
  bit   slave_auto = 0;
  exp_t exp_q0[$];
  exp_t exp_q1[$];
  dir_t dir_q[$];

  iomem_arbiter #(
    .TIMEOUT_CYCLES(TO),
    .ERR_RDATA     (ERR)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .m0_valid(mv[0]),
    .m0_ready(m0_ready),
    .m0_wstrb(mws[0]),
    .m0_addr (ma[0]),
    .m0_wdata(mwd[0]),
    .m0_rdata(m0_rdata),
    .m1_valid(mv[1]),
    .m1_ready(m1_ready),
    .m1_wstrb(mws[1]),
    .m1_addr (ma[1]),
    .m1_wdata(mwd[1]),
    .m1_rdata(m1_rdata),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_wstrb (s_wstrb),
    .s_addr  (s_addr),
    .s_wdata (s_wdata),
    .s_rdata (s_rdata),
    .timeout (timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input bit ok, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk(act === exp, name, act, exp);
  endtask

  // Slave behaviour in random mode is a pure function of the request address.
  function automatic int delay_of(input logic [31:0] a);
    return 1 + int'((a >> 2) % 32'd10);
  endfunction

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  task automatic push_dir(input int d, input logic [31:0] data);
    dir_t t;
    t.d    = d;
    t.data = data;
    dir_q.push_back(t);
  endtask

  // Called just after a rising edge; lat is the cycle of the ready pulse relative to valid rise.
  task automatic issue(input int n, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] ws, input logic [31:0] erd, input bit eto,
                       output int lat);
    exp_t e;
    int   c0;
    bit   got;
    e.rd = erd;
    e.to = eto;
    if (n == 0) exp_q0.push_back(e);
    else exp_q1.push_back(e);
    issued++;
    ma[n]  = a;
    mwd[n] = wd;
    mws[n] = ws;
    mv[n]  = 1'b1;
    c0  = cyc;
    got = 1'b0;
    lat = -1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if ((n == 0) ? m0_ready : m1_ready) begin
        got = 1'b1;
        lat = cyc - c0;
      end
    end
    chk_eq($sformatf("m%0d_ready_within_bound", n), 32'(got), 32'd1);
    @(posedge clk);
    #1;
    mv[n] = 1'b0;
  endtask

  task automatic rand_driver(input int n, input int count);
    logic [31:0] a, wd;
    logic [3:0]  ws;
    int          d, lat;
    bit          to;
    for (int k = 0; k < count; k++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      a  = $urandom;
      wd = $urandom;
      ws = 4'($urandom_range(0, 15));
      d  = delay_of(a);
      to = (d > int'(TO));
      issue(n, a, wd, ws, to ? ERR : data_of(a), to, lat);
    end
  endtask

  task automatic check_resp(input int n, input logic [31:0] rd);
    exp_t e;
    int   sz;
    sz = (n == 0) ? exp_q0.size() : exp_q1.size();
    chk(sz > 0, $sformatf("m%0d_spurious_ready", n), 32'(sz), 32'd1);
    if (sz > 0) begin
      e = (n == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      chk_eq($sformatf("m%0d_rdata", n), rd, e.rd);
      chk_eq($sformatf("m%0d_timeout", n), 32'(timeout), 32'(e.to));
    end
    last_served = n;
    done++;
  endtask

  // Monitor: pops the scoreboard on every ready pulse and checks per-cycle invariants.
  initial begin
    forever begin
      @(negedge clk);
      if (resetn) begin
        chk_eq("single_ready", 32'(m0_ready && m1_ready), 32'd0);
        chk_eq("s_valid_in_resp", 32'((m0_ready || m1_ready) && s_valid), 32'd0);
        chk_eq("timeout_without_ready", 32'(timeout && !m0_ready && !m1_ready), 32'd0);
        if (m0_ready) check_resp(0, m0_rdata);
        if (m1_ready) check_resp(1, m1_rdata);
        if (s_valid) sv_cnt++;
      end
    end
  end

  // Slave model with a reference arbiter choosing which requester should own each transfer.
  initial begin
    int          busy_n;
    int          cur_d;
    int          sel;
    logic [31:0] cur_data;
    bit          pv0, pv1;
    dir_t        dc;
    busy_n = 0;
    cur_d = 0;
    sel = 0;
    cur_data = 32'd0;
    pv0 = 1'b0;
    pv1 = 1'b0;
    s_ready = 1'b0;
    s_rdata = 32'd0;
    forever begin
      @(negedge clk);
      s_ready = 1'b0;
      if (!resetn || !s_valid) begin
        busy_n = 0;
      end else begin
        busy_n++;
        if (busy_n == 1) begin
          chk_eq("grant_had_request", 32'(pv0 || pv1), 32'd1);
          sel = (pv0 && pv1) ? ((last_served == 1) ? 0 : 1) : (pv1 ? 1 : 0);
          if (slave_auto) begin
            cur_d    = delay_of(ma[sel]);
            cur_data = data_of(ma[sel]);
          end else if (dir_q.size() > 0) begin
            dc       = dir_q.pop_front();
            cur_d    = dc.d;
            cur_data = dc.data;
          end else begin
            cur_d = 0;
          end
        end
        chk_eq("s_addr", s_addr, ma[sel]);
        chk_eq("s_wdata", s_wdata, mwd[sel]);
        chk_eq("s_wstrb", 32'(s_wstrb), 32'(mws[sel]));
        if (busy_n == cur_d) begin
          s_ready = 1'b1;
          s_rdata = cur_data;
        end
      end
      pv0 = resetn && mv[0];
      pv1 = resetn && mv[1];
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got simulation still running, required completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat0, lat1, lat;
    for (int i = 0; i < 2; i++) begin
      mv[i]  = 1'b0;
      ma[i]  = 32'd0;
      mwd[i] = 32'd0;
      mws[i] = 4'd0;
    end
    resetn = 1'b0;
    last_served = 1;
    #1;
    chk_eq("rst_s_valid", 32'(s_valid), 32'd0);
    chk_eq("rst_m0_ready", 32'(m0_ready), 32'd0);
    chk_eq("rst_m1_ready", 32'(m1_ready), 32'd0);
    chk_eq("rst_timeout", 32'(timeout), 32'd0);
    chk_eq("rst_s_addr", s_addr, 32'd0);
    chk_eq("rst_s_wdata", s_wdata, 32'd0);
    chk_eq("rst_s_wstrb", 32'(s_wstrb), 32'd0);
    chk_eq("rst_m0_rdata", m0_rdata, 32'd0);
    chk_eq("rst_m1_rdata", m1_rdata, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;

    // Simultaneous reads from reset: m0 first, then m1.
    push_dir(2, 32'h1111_1111);
    push_dir(3, 32'h2222_2222);
    fork
      issue(0, 32'h0300_0010, 32'd0, 4'h0, 32'h1111_1111, 1'b0, lat0);
      issue(1, 32'h0300_0020, 32'd0, 4'h0, 32'h2222_2222, 1'b0, lat1);
    join
    chk_eq("tie1_m0_latency", 32'(lat0), 32'd3);
    chk_eq("tie1_m1_latency", 32'(lat1), 32'd8);

    // m1 was served last, so the next tie goes to m0.
    push_dir(1, 32'h3333_0000);
    push_dir(1, 32'h4444_0000);
    fork
      issue(0, 32'h0300_0030, 32'd0, 4'h0, 32'h3333_0000, 1'b0, lat0);
      issue(1, 32'h0300_0034, 32'd0, 4'h0, 32'h4444_0000, 1'b0, lat1);
    join
    chk_eq("tie2_m0_latency", 32'(lat0), 32'd2);
    chk_eq("tie2_m1_latency", 32'(lat1), 32'd5);

    // Single write, slave ready in second BUSY cycle.
    push_dir(2, 32'h0000_0000);
    sv_cnt = 0;
    issue(0, 32'h0300_0000, 32'h0000_00A5, 4'hF, 32'h0000_0000, 1'b0, lat);
    chk_eq("wr_latency", 32'(lat), 32'd3);
    chk_eq("wr_s_valid_cycles", 32'(sv_cnt), 32'd2);
    chk_eq("hold_s_addr", s_addr, 32'h0300_0000);
    chk_eq("hold_s_wdata", s_wdata, 32'h0000_00A5);
    chk_eq("hold_s_wstrb", 32'(s_wstrb), 32'hF);

    // Slave never answers: timeout after four BUSY cycles.
    push_dir(0, 32'd0);
    sv_cnt = 0;
    issue(1, 32'h0300_0040, 32'd0, 4'h0, ERR, 1'b1, lat);
    chk_eq("to_latency", 32'(lat), 32'd5);
    chk_eq("to_s_valid_cycles", 32'(sv_cnt), 32'd4);

    // Slave answers in the timeout cycle: response wins.
    push_dir(4, 32'hCAFE_0001);
    sv_cnt = 0;
    issue(1, 32'h0300_0044, 32'd0, 4'h0, 32'hCAFE_0001, 1'b0, lat);
    chk_eq("late_latency", 32'(lat), 32'd5);
    chk_eq("late_s_valid_cycles", 32'(sv_cnt), 32'd4);

    // Asynchronous reset in the middle of a transfer.
    push_dir(0, 32'd0);
    ma[0]  = 32'h0300_0080;
    mwd[0] = 32'h0000_0055;
    mws[0] = 4'h3;
    mv[0]  = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    resetn = 1'b0;
    last_served = 1;
    #1;
    chk_eq("mid_rst_s_valid", 32'(s_valid), 32'd0);
    chk_eq("mid_rst_m0_ready", 32'(m0_ready), 32'd0);
    chk_eq("mid_rst_timeout", 32'(timeout), 32'd0);
    chk_eq("mid_rst_s_addr", s_addr, 32'd0);
    chk_eq("mid_rst_s_wstrb", 32'(s_wstrb), 32'd0);
    chk_eq("mid_rst_m1_rdata", m1_rdata, 32'd0);
    mv[0] = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    push_dir(2, 32'h1234_5678);
    issue(0, 32'h0300_0084, 32'h0000_0055, 4'hF, 32'h1234_5678, 1'b0, lat);
    chk_eq("post_rst_latency", 32'(lat), 32'd3);

    // Random back-to-back traffic on both requesters.
    slave_auto = 1'b1;
    fork
      rand_driver(0, 500);
      rand_driver(1, 500);
    join
    repeat (5) @(posedge clk);
    chk_eq("m0_queue_drained", 32'(exp_q0.size()), 32'd0);
    chk_eq("m1_queue_drained", 32'(exp_q1.size()), 32'd0);
    chk_eq("completed_count", 32'(done), 32'(issued));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
